// File: rtl/io_strobe_pkg.sv
// Shared types for the I/O strobe sequencer and its decode helpers.
package io_strobe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    typedef enum logic {
        DIR_RD,
        DIR_WR
    } dir_t;

    // Width of an encoded index over n selects (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_sel_check.sv
// Classifies an active-low select vector as none / one-hot / multiple
// and encodes the index of the (last) asserted select.
module io_sel_check
    import io_strobe_pkg::*;
#(
    parameter int NSEL = 4
) (
    input  logic [NSEL-1:0]            sel_n,
    output logic                       one_hot,
    output logic                       none,
    output logic                       multi,
    output logic [idx_width(NSEL)-1:0] idx
);

    localparam int IDXW = idx_width(NSEL);

    logic [IDXW:0] low_count;

    // Count asserted selects and remember the position of one of them.
    always_comb begin
        low_count = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NSEL; i++) begin
            if (!sel_n[i]) begin
                low_count = low_count + 1'b1;
                idx       = IDXW'(i);
            end
        end
    end

    assign none    = (low_count == '0);
    assign one_hot = (low_count == (IDXW + 1)'(1));
    assign multi   = (low_count > (IDXW + 1)'(1));

endmodule

// File: rtl/io_strobe_seq.sv
// I/O cycle sequencer: turns decoded selects plus IOR/IOW requests into
// timed CS/RD/WR strobes with per-select wait states and a READY pulse.
module io_strobe_seq
    import io_strobe_pkg::*;
#(
    parameter int NSEL  = 4,
    parameter int WAITW = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NSEL-1:0]        SEL_N,
    input  logic                   IOR,
    input  logic                   IOW,
    input  logic [NSEL*WAITW-1:0]  WAITS,
    output logic [NSEL-1:0]        CS_N,
    output logic                   RD_N,
    output logic                   WR_N,
    output logic                   READY,
    output logic                   ERR
);

    localparam int IDXW = idx_width(NSEL);

    state_t            state, state_nx;
    dir_t              dir_q, dir_nx;
    logic [WAITW-1:0]  cnt, cnt_nx;
    logic              err_q, err_pend_nx;
    logic              ior_q, iow_q;
    logic [NSEL-1:0]   cs_n_nx;
    logic              rd_n_nx, wr_n_nx, ready_nx, err_nx;

    logic              sel_one_hot, sel_none, sel_multi;
    logic [IDXW-1:0]   sel_idx;
    logic              rd_rise, wr_rise;

    io_sel_check #(
        .NSEL(NSEL)
    ) u_sel_check (
        .sel_n   (SEL_N),
        .one_hot (sel_one_hot),
        .none    (sel_none),
        .multi   (sel_multi),
        .idx     (sel_idx)
    );

    assign rd_rise = IOR & ~ior_q;
    assign wr_rise = IOW & ~iow_q;

    // Next-state, counter and registered-output decisions.
    always_comb begin
        state_nx    = state;
        dir_nx      = dir_q;
        cnt_nx      = cnt;
        err_pend_nx = err_q;
        cs_n_nx     = CS_N;
        rd_n_nx     = RD_N;
        wr_n_nx     = WR_N;
        ready_nx    = 1'b0;
        err_nx      = 1'b0;

        unique case (state)
            IDLE: begin
                if (rd_rise || wr_rise) begin
                    if (sel_none || sel_multi || (rd_rise && wr_rise)) begin
                        state_nx    = DONE;
                        err_pend_nx = 1'b1;
                    end else if (sel_one_hot) begin
                        state_nx         = SETUP;
                        dir_nx           = rd_rise ? DIR_RD : DIR_WR;
                        cnt_nx           = WAITS[sel_idx*WAITW +: WAITW];
                        cs_n_nx          = '1;
                        cs_n_nx[sel_idx] = 1'b0;
                    end
                end
            end
            SETUP: begin
                state_nx = STROBE;
                if (dir_q == DIR_RD) rd_n_nx = 1'b0;
                else                 wr_n_nx = 1'b0;
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nx = HOLD;
                    rd_n_nx  = 1'b1;
                    wr_n_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            HOLD: begin
                state_nx = DONE;
                cs_n_nx  = '1;
                ready_nx = 1'b1;
            end
            DONE: begin
                // A normal cycle arrives here with READY already raised; an
                // error cycle arrives with READY low and raises it one edge
                // later, so both paths hold READY for exactly one cycle.
                if (READY) begin
                    state_nx    = IDLE;
                    err_pend_nx = 1'b0;
                end else begin
                    ready_nx = 1'b1;
                    err_nx   = err_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, history and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            dir_q <= DIR_RD;
            cnt   <= '0;
            err_q <= 1'b0;
            ior_q <= 1'b0;
            iow_q <= 1'b0;
            CS_N  <= '1;
            RD_N  <= 1'b1;
            WR_N  <= 1'b1;
            READY <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            state <= state_nx;
            dir_q <= dir_nx;
            cnt   <= cnt_nx;
            err_q <= err_pend_nx;
            ior_q <= IOR;
            iow_q <= IOW;
            CS_N  <= cs_n_nx;
            RD_N  <= rd_n_nx;
            WR_N  <= wr_n_nx;
            READY <= ready_nx;
            ERR   <= err_nx;
        end
    end

endmodule

// File: tb/tb_io_strobe_seq.sv
// Scoreboard bench for io_strobe_seq: the driver queues expected
// transactions, a monitor measures strobe widths/latency on each READY.
module tb_io_strobe_seq;

    logic        CLK;
    logic        RESET;
    logic [3:0]  SEL_N;
    logic        IOR;
    logic        IOW;
    logic [11:0] WAITS;
    logic [3:0]  CS_N;
    logic        RD_N;
    logic        WR_N;
    logic        READY;
    logic        ERR;

    io_strobe_seq #(
        .NSEL  (4),
        .WAITW (3)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .SEL_N (SEL_N),
        .IOR   (IOR),
        .IOW   (IOW),
        .WAITS (WAITS),
        .CS_N  (CS_N),
        .RD_N  (RD_N),
        .WR_N  (WR_N),
        .READY (READY),
        .ERR   (ERR)
    );

    typedef struct {
        bit          err;
        bit          wr;
        int unsigned idx;
        int unsigned w;
        int          issue;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int unsigned passed = 0;
    int unsigned total = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: classify the request from the selects and request lines.
    function automatic exp_t model(input logic rd, input logic wr, input logic [3:0] sn,
                                   input logic [11:0] wv, input int issue);
        exp_t        e;
        int unsigned nlow;
        nlow  = 0;
        e.idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (!sn[i]) begin
                nlow++;
                e.idx = i;
            end
        end
        e.err   = (rd && wr) || (nlow != 1);
        e.wr    = wr;
        e.w     = 32'(wv[e.idx*3 +: 3]);
        e.issue = issue;
        return e;
    endfunction

    // Monitor: accumulate activity, compare against the queue on READY.
    task automatic monitor();
        int unsigned cs_cnt, rd_cnt, wr_cnt, lat, wid;
        logic [3:0]  cs_mask, exp_mask;
        logic        rdy_prev;
        exp_t        e;
        cs_cnt = 0; rd_cnt = 0; wr_cnt = 0; cs_mask = '0; rdy_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                cs_cnt = 0; rd_cnt = 0; wr_cnt = 0; cs_mask = '0; rdy_prev = 1'b0;
            end else begin
                if (CS_N != 4'hF) begin
                    cs_cnt++;
                    cs_mask = cs_mask | ~CS_N;
                end
                if (!RD_N) rd_cnt++;
                if (!WR_N) wr_cnt++;
                if (ERR && !READY) chk("err_without_ready", 32'(ERR), 0);
                if (READY) begin
                    chk("ready_width", 32'(rdy_prev), 0);
                    if (sb.size() == 0) begin
                        chk("unexpected_ready", 32'(READY), 0);
                    end else begin
                        e        = sb.pop_front();
                        lat      = e.err ? 1 : e.w + 3;
                        wid      = e.err ? 0 : e.w + 1;
                        exp_mask = e.err ? 4'h0 : 4'(1 << e.idx);
                        chk("err_flag", 32'(ERR), 32'(e.err));
                        chk("latency", cyc - e.issue, lat);
                        chk("cs_select", 32'(cs_mask), 32'(exp_mask));
                        chk("cs_width", cs_cnt, e.err ? 0 : e.w + 3);
                        chk("rd_width", rd_cnt, (!e.wr) ? wid : 0);
                        chk("wr_width", wr_cnt, e.wr ? wid : 0);
                    end
                    cs_cnt = 0; rd_cnt = 0; wr_cnt = 0; cs_mask = '0;
                end
                rdy_prev = READY;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cs_n"}, 32'(CS_N), 32'hF);
        chk({tag, "_rd_n"}, 32'(RD_N), 1);
        chk({tag, "_wr_n"}, 32'(WR_N), 1);
        chk({tag, "_ready"}, 32'(READY), 0);
        chk({tag, "_err"}, 32'(ERR), 0);
    endtask

    // Called at negedge+1 after the request is driven; scrambles SEL_N and
    // WAITS after latching, drops the request after 'hold' cycles, and
    // returns one IDLE cycle after the queue drains.
    task automatic finish_txn(input int unsigned hold);
        int unsigned n;
        n = 0;
        forever begin
            @(negedge CLK); #1;
            n++;
            SEL_N = 4'($urandom);
            WAITS = 12'($urandom);
            if (n >= hold) begin
                IOR = 1'b0;
                IOW = 1'b0;
            end
            if (sb.size() == 0 && n >= hold) break;
            if (n > 300) begin
                chk("txn_timeout", 32'(sb.size()), 0);
                sb.delete();
                break;
            end
        end
        IOR = 1'b0;
        IOW = 1'b0;
        @(negedge CLK); #1;
    endtask

    task automatic do_txn(input logic rd, input logic wr, input logic [3:0] sn,
                          input logic [11:0] wv, input int unsigned hold);
        SEL_N = sn;
        WAITS = wv;
        IOR   = rd;
        IOW   = wr;
        sb.push_back(model(rd, wr, sn, wv, cyc + 1));
        finish_txn(hold);
    endtask

    task automatic reset_abort();
        logic [11:0] wv;
        int unsigned n;
        wv    = {3'd7, 9'($urandom)};
        SEL_N = 4'b0111;
        WAITS = wv;
        IOR   = 1'b1;
        IOW   = 1'b0;
        sb.push_back(model(1'b1, 1'b0, 4'b0111, wv, cyc + 1));
        n = 0;
        while (RD_N !== 1'b0 && n < 10) begin
            @(negedge CLK); #1;
            n++;
        end
        chk("abort_strobe_active", 32'(RD_N), 0);
        IOR = 1'b0;
        @(negedge CLK); #1;
        #3 RESET = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        sb.delete();
        // Request already high while reset releases must still be seen.
        SEL_N = 4'b1101;
        IOR   = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        wv    = 12'($urandom);
        WAITS = wv;
        RESET = 1'b0;
        sb.push_back(model(1'b1, 1'b0, 4'b1101, wv, cyc + 1));
        finish_txn(3);
    endtask

    initial begin
        RESET = 1'b1;
        IOR   = 1'b0;
        IOW   = 1'b0;
        SEL_N = 4'hF;
        WAITS = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge CLK);
        #1;
        chk_reset_vals("reset");
        RESET = 1'b0;
        @(negedge CLK); #1;

        do_txn(1'b1, 1'b0, 4'b1011, {3'd5, 3'd0, 3'd3, 3'd6}, 2);
        do_txn(1'b0, 1'b1, 4'b1110, {3'd1, 3'd2, 3'd4, 3'd7}, 3);
        do_txn(1'b1, 1'b0, 4'b1111, 12'($urandom), 1);
        do_txn(1'b1, 1'b0, 4'b1010, 12'($urandom), 1);
        do_txn(1'b1, 1'b1, 4'b1101, 12'($urandom), 2);
        do_txn(1'b1, 1'b0, 4'b1101, 12'($urandom), 30);
        reset_abort();

        for (int k = 0; k < 40; k++) begin
            logic [3:0]  sn;
            logic        r, w;
            int unsigned m;
            m = $urandom_range(0, 7);
            r = (m < 4);
            w = (m == 0) || (m >= 4);
            if ($urandom_range(0, 3) != 0) sn = ~(4'b0001 << $urandom_range(0, 3));
            else                           sn = 4'($urandom);
            do_txn(r, w, sn, 12'($urandom), $urandom_range(1, 12));
        end

        repeat (5) @(negedge CLK);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
